// File: rtl/reservation_station_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station_pkg
// Description : Shared types, opcode codes and sizing for the reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
package reservation_station_pkg;

    localparam int OPENUM_W = 6;
    localparam int ROB_ID_W = 5;
    localparam int RS_SIZE  = 16;
    localparam int RS_ID_W  = 4;

    typedef logic [OPENUM_W-1:0] openum_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [RS_ID_W-1:0]  rs_id_t;

    localparam rob_id_t ZERO_ROB = '0;

    localparam openum_t OPENUM_NOP = 6'd0;
    localparam openum_t OPENUM_ADD = 6'd1;
    localparam openum_t OPENUM_SUB = 6'd2;
    localparam openum_t OPENUM_AND = 6'd3;
    localparam openum_t OPENUM_OR  = 6'd4;
    localparam openum_t OPENUM_XOR = 6'd5;

    typedef struct packed {
        openum_t     openum;
        logic [31:0] v1;
        logic [31:0] v2;
        rob_id_t     q1;
        rob_id_t     q2;
        logic [31:0] pc;
        logic [31:0] imm;
        rob_id_t     rob_id;
    } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/reservation_station_if.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station_if
// Description : Dispatch, CDB snoop, flush and ALU issue signals of the station.
// Revision    : 1.0 - initial release
// ============================================================================
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic        rdy;
    logic        ena_from_dsp;
    openum_t     openum_from_dsp;
    logic [31:0] V1_from_dsp;
    logic [31:0] V2_from_dsp;
    rob_id_t     Q1_from_dsp;
    rob_id_t     Q2_from_dsp;
    logic [31:0] pc_from_dsp;
    logic [31:0] imm_from_dsp;
    rob_id_t     rob_id_from_dsp;
    logic        valid_from_rs_cdb;
    rob_id_t     rob_id_from_rs_cdb;
    logic [31:0] result_from_rs_cdb;
    logic        valid_from_ls_cdb;
    rob_id_t     rob_id_from_ls_cdb;
    logic [31:0] result_from_ls_cdb;
    logic        commit_jump_flag_from_rob;
    logic        full_to_if;
    logic        ena_to_alu;
    openum_t     openum_to_alu;
    logic [31:0] V1_to_alu;
    logic [31:0] V2_to_alu;
    logic [31:0] pc_to_alu;
    logic [31:0] imm_to_alu;
    rob_id_t     rob_id_to_alu;

    modport master (
        output rdy, ena_from_dsp, openum_from_dsp, V1_from_dsp, V2_from_dsp,
               Q1_from_dsp, Q2_from_dsp, pc_from_dsp, imm_from_dsp, rob_id_from_dsp,
               valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb,
               valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb,
               commit_jump_flag_from_rob,
        input  full_to_if, ena_to_alu, openum_to_alu, V1_to_alu, V2_to_alu,
               pc_to_alu, imm_to_alu, rob_id_to_alu
    );

    modport slave (
        input  rdy, ena_from_dsp, openum_from_dsp, V1_from_dsp, V2_from_dsp,
               Q1_from_dsp, Q2_from_dsp, pc_from_dsp, imm_from_dsp, rob_id_from_dsp,
               valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb,
               valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb,
               commit_jump_flag_from_rob,
        output full_to_if, ena_to_alu, openum_to_alu, V1_to_alu, V2_to_alu,
               pc_to_alu, imm_to_alu, rob_id_to_alu
    );

endinterface
`default_nettype wire

// File: rtl/reservation_station_rs_find_first.sv
`default_nettype none
// ============================================================================
// Module      : rs_find_first
// Description : Lowest-set-bit finder returning a found flag and the bit index.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_find_first #(
    parameter int SIZE = 16,
    parameter int ID_W = 4
) (
    input  wire logic [SIZE-1:0] vec,
    output logic                 found,
    output logic [ID_W-1:0]      index
);

    // Scanning downward lets the lowest set bit be the final assignment.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                index = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station
// Description : Holds renamed ALU instructions until operands arrive; issues one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = 16,
    parameter int RS_ID_W = 4
) (
    input wire logic             clk,
    input wire logic             rst,
    reservation_station_if.slave bus
);

    logic [RS_SIZE-1:0] r_busy;
    rs_entry_t          r_entry [RS_SIZE];

    logic [RS_SIZE-1:0] w_ready;
    rs_entry_t          w_woken [RS_SIZE];
    rs_entry_t          w_new;
    logic               w_free_found;
    logic [RS_ID_W-1:0] w_free_idx;
    logic               w_ready_found;
    logic [RS_ID_W-1:0] w_ready_idx;
    logic [RS_ID_W:0]   w_busy_count;

    generate
        for (genvar i = 0; i < RS_SIZE; i++) begin : g_entry
            logic w_q1_rs, w_q1_ls, w_q2_rs, w_q2_ls;
            assign w_q1_rs = bus.valid_from_rs_cdb && r_entry[i].q1 != ZERO_ROB
                             && r_entry[i].q1 == bus.rob_id_from_rs_cdb;
            assign w_q1_ls = bus.valid_from_ls_cdb && r_entry[i].q1 != ZERO_ROB
                             && r_entry[i].q1 == bus.rob_id_from_ls_cdb;
            assign w_q2_rs = bus.valid_from_rs_cdb && r_entry[i].q2 != ZERO_ROB
                             && r_entry[i].q2 == bus.rob_id_from_rs_cdb;
            assign w_q2_ls = bus.valid_from_ls_cdb && r_entry[i].q2 != ZERO_ROB
                             && r_entry[i].q2 == bus.rob_id_from_ls_cdb;
            assign w_ready[i] = r_busy[i] && r_entry[i].q1 == ZERO_ROB
                                && r_entry[i].q2 == ZERO_ROB;

            always_comb begin
                w_woken[i] = r_entry[i];
                if (w_q1_rs) begin
                    w_woken[i].v1 = bus.result_from_rs_cdb;
                    w_woken[i].q1 = ZERO_ROB;
                end else if (w_q1_ls) begin
                    w_woken[i].v1 = bus.result_from_ls_cdb;
                    w_woken[i].q1 = ZERO_ROB;
                end
                if (w_q2_rs) begin
                    w_woken[i].v2 = bus.result_from_rs_cdb;
                    w_woken[i].q2 = ZERO_ROB;
                end else if (w_q2_ls) begin
                    w_woken[i].v2 = bus.result_from_ls_cdb;
                    w_woken[i].q2 = ZERO_ROB;
                end
            end
        end
    endgenerate

    // Incoming operands may be satisfied by a broadcast in the dispatch cycle itself.
    always_comb begin
        w_new.openum = bus.openum_from_dsp;
        w_new.v1     = bus.V1_from_dsp;
        w_new.v2     = bus.V2_from_dsp;
        w_new.q1     = bus.Q1_from_dsp;
        w_new.q2     = bus.Q2_from_dsp;
        w_new.pc     = bus.pc_from_dsp;
        w_new.imm    = bus.imm_from_dsp;
        w_new.rob_id = bus.rob_id_from_dsp;
        if (bus.Q1_from_dsp != ZERO_ROB) begin
            if (bus.valid_from_rs_cdb && bus.rob_id_from_rs_cdb == bus.Q1_from_dsp) begin
                w_new.v1 = bus.result_from_rs_cdb;
                w_new.q1 = ZERO_ROB;
            end else if (bus.valid_from_ls_cdb && bus.rob_id_from_ls_cdb == bus.Q1_from_dsp) begin
                w_new.v1 = bus.result_from_ls_cdb;
                w_new.q1 = ZERO_ROB;
            end
        end
        if (bus.Q2_from_dsp != ZERO_ROB) begin
            if (bus.valid_from_rs_cdb && bus.rob_id_from_rs_cdb == bus.Q2_from_dsp) begin
                w_new.v2 = bus.result_from_rs_cdb;
                w_new.q2 = ZERO_ROB;
            end else if (bus.valid_from_ls_cdb && bus.rob_id_from_ls_cdb == bus.Q2_from_dsp) begin
                w_new.v2 = bus.result_from_ls_cdb;
                w_new.q2 = ZERO_ROB;
            end
        end
    end

    rs_find_first #(.SIZE(RS_SIZE), .ID_W(RS_ID_W)) u_free_finder (
        .vec   (~r_busy),
        .found (w_free_found),
        .index (w_free_idx)
    );

    rs_find_first #(.SIZE(RS_SIZE), .ID_W(RS_ID_W)) u_ready_finder (
        .vec   (w_ready),
        .found (w_ready_found),
        .index (w_ready_idx)
    );

    always_comb begin
        w_busy_count = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_busy_count = w_busy_count + {{RS_ID_W{1'b0}}, r_busy[i]};
        end
    end

    // One slot stays in reserve for the dispatch already in flight when fetch stalls.
    assign bus.full_to_if = w_busy_count >= (RS_ID_W + 1)'(RS_SIZE - 1);

    // The free slot comes from start-of-cycle busy bits, so it never collides with the issuing slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy            <= '0;
            bus.ena_to_alu    <= 1'b0;
            bus.openum_to_alu <= '0;
            bus.V1_to_alu     <= '0;
            bus.V2_to_alu     <= '0;
            bus.pc_to_alu     <= '0;
            bus.imm_to_alu    <= '0;
            bus.rob_id_to_alu <= '0;
        end else if (!bus.rdy) begin
            bus.ena_to_alu <= 1'b0;
        end else if (bus.commit_jump_flag_from_rob) begin
            r_busy         <= '0;
            bus.ena_to_alu <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    r_entry[i] <= w_woken[i];
                end
            end
            bus.ena_to_alu <= w_ready_found;
            if (w_ready_found) begin
                r_busy[w_ready_idx] <= 1'b0;
                bus.openum_to_alu   <= r_entry[w_ready_idx].openum;
                bus.V1_to_alu       <= r_entry[w_ready_idx].v1;
                bus.V2_to_alu       <= r_entry[w_ready_idx].v2;
                bus.pc_to_alu       <= r_entry[w_ready_idx].pc;
                bus.imm_to_alu      <= r_entry[w_ready_idx].imm;
                bus.rob_id_to_alu   <= r_entry[w_ready_idx].rob_id;
            end
            if (bus.ena_from_dsp && w_free_found) begin
                r_busy[w_free_idx]  <= 1'b1;
                r_entry[w_free_idx] <= w_new;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_reservation_station
// Description : Directed self-checking bench for reservation_station.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    reservation_station_if bus ();

    reservation_station #(.RS_SIZE(16), .RS_ID_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ena_from_dsp              = 1'b0;
        bus.openum_from_dsp           = OPENUM_NOP;
        bus.V1_from_dsp               = '0;
        bus.V2_from_dsp               = '0;
        bus.Q1_from_dsp               = ZERO_ROB;
        bus.Q2_from_dsp               = ZERO_ROB;
        bus.pc_from_dsp               = '0;
        bus.imm_from_dsp              = '0;
        bus.rob_id_from_dsp           = ZERO_ROB;
        bus.valid_from_rs_cdb         = 1'b0;
        bus.rob_id_from_rs_cdb        = ZERO_ROB;
        bus.result_from_rs_cdb        = '0;
        bus.valid_from_ls_cdb         = 1'b0;
        bus.rob_id_from_ls_cdb        = ZERO_ROB;
        bus.result_from_ls_cdb        = '0;
        bus.commit_jump_flag_from_rob = 1'b0;
    endtask

    task automatic dispatch(input openum_t op, input logic [31:0] v1, input logic [31:0] v2,
                            input rob_id_t q1, input rob_id_t q2, input rob_id_t rob);
        bus.ena_from_dsp    = 1'b1;
        bus.openum_from_dsp = op;
        bus.V1_from_dsp     = v1;
        bus.V2_from_dsp     = v2;
        bus.Q1_from_dsp     = q1;
        bus.Q2_from_dsp     = q2;
        bus.pc_from_dsp     = 32'h1000 + {27'd0, rob};
        bus.imm_from_dsp    = 32'h20 + {27'd0, rob};
        bus.rob_id_from_dsp = rob;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.rdy = 1'b1;
        tick();
        tick();
        checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL reset_ena got=%b exp=0", bus.ena_to_alu); end
        checks++; if (bus.full_to_if !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full_to_if); end
        checks++; if (bus.V1_to_alu !== 32'd0 || bus.rob_id_to_alu !== ZERO_ROB) begin
            failures++; $display("FAIL reset_data got V1=%h rob=%0d exp 0/0", bus.V1_to_alu, bus.rob_id_to_alu); end
        rst = 1'b0;
        tick();
        checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL reset_idle_ena got=%b exp=0", bus.ena_to_alu); end
    endtask

    task automatic test_ready_dispatch();
        dispatch(OPENUM_ADD, 32'd5, 32'd7, ZERO_ROB, ZERO_ROB, 5'd3);
        tick();
        clear_inputs();
        checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL ready_early_issue got=%b exp=0", bus.ena_to_alu); end
        tick();
        checks++; if (bus.ena_to_alu !== 1'b1) begin failures++; $display("FAIL ready_issue got=%b exp=1", bus.ena_to_alu); end
        checks++; if (bus.V1_to_alu !== 32'd5 || bus.V2_to_alu !== 32'd7) begin
            failures++; $display("FAIL ready_vals got=%0d/%0d exp=5/7", bus.V1_to_alu, bus.V2_to_alu); end
        checks++; if (bus.rob_id_to_alu !== 5'd3 || bus.openum_to_alu !== OPENUM_ADD) begin
            failures++; $display("FAIL ready_tag got rob=%0d op=%0d exp 3/1", bus.rob_id_to_alu, bus.openum_to_alu); end
        checks++; if (bus.pc_to_alu !== 32'h1003 || bus.imm_to_alu !== 32'h23) begin
            failures++; $display("FAIL ready_pc_imm got=%h/%h exp=1003/23", bus.pc_to_alu, bus.imm_to_alu); end
        tick();
        checks++; if (bus.ena_to_alu !== 1'b0 || bus.V1_to_alu !== 32'd5) begin
            failures++; $display("FAIL ready_hold got ena=%b V1=%0d exp 0/5", bus.ena_to_alu, bus.V1_to_alu); end
    endtask

    task automatic test_rdy_freeze();
        bus.rdy = 1'b0;
        dispatch(OPENUM_SUB, 32'd1, 32'd2, ZERO_ROB, ZERO_ROB, 5'd9);
        tick();
        clear_inputs();
        tick();
        bus.rdy = 1'b1;
        tick();
        checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL rdy_dispatch_ignored got=%b exp=0", bus.ena_to_alu); end
        dispatch(OPENUM_SUB, 32'd1, 32'd2, ZERO_ROB, ZERO_ROB, 5'd10);
        tick();
        clear_inputs();
        bus.rdy = 1'b0;
        tick();
        checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL rdy_freeze_issue got=%b exp=0", bus.ena_to_alu); end
        bus.rdy = 1'b1;
        tick();
        checks++; if (bus.ena_to_alu !== 1'b1 || bus.rob_id_to_alu !== 5'd10) begin
            failures++; $display("FAIL rdy_resume got ena=%b rob=%0d exp 1/10", bus.ena_to_alu, bus.rob_id_to_alu); end
        tick();
    endtask

    task automatic test_wakeup();
        dispatch(OPENUM_AND, 32'd0, 32'd1, 5'd2, ZERO_ROB, 5'd4);
        tick();
        clear_inputs();
        tick();
        checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL wake_waiting got=%b exp=0", bus.ena_to_alu); end
        bus.valid_from_ls_cdb  = 1'b1;
        bus.rob_id_from_ls_cdb = 5'd2;
        bus.result_from_ls_cdb = 32'hDEAD;
        tick();
        clear_inputs();
        checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL wake_same_cycle got=%b exp=0", bus.ena_to_alu); end
        tick();
        checks++; if (bus.ena_to_alu !== 1'b1 || bus.V1_to_alu !== 32'hDEAD || bus.rob_id_to_alu !== 5'd4) begin
            failures++; $display("FAIL wake_issue got ena=%b V1=%h rob=%0d exp 1/dead/4", bus.ena_to_alu, bus.V1_to_alu, bus.rob_id_to_alu); end
        tick();
    endtask

    task automatic test_simul_snoop();
        dispatch(OPENUM_OR, 32'd0, 32'd0, 5'd4, 5'd5, 5'd12);
        bus.valid_from_rs_cdb  = 1'b1;
        bus.rob_id_from_rs_cdb = 5'd4;
        bus.result_from_rs_cdb = 32'd9;
        bus.valid_from_ls_cdb  = 1'b1;
        bus.rob_id_from_ls_cdb = 5'd5;
        bus.result_from_ls_cdb = 32'd11;
        tick();
        clear_inputs();
        checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL snoop_early got=%b exp=0", bus.ena_to_alu); end
        tick();
        checks++; if (bus.ena_to_alu !== 1'b1 || bus.V1_to_alu !== 32'd9 || bus.V2_to_alu !== 32'd11) begin
            failures++; $display("FAIL snoop_issue got ena=%b V1=%0d V2=%0d exp 1/9/11", bus.ena_to_alu, bus.V1_to_alu, bus.V2_to_alu); end
        tick();
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 16; k++) begin
            dispatch(OPENUM_XOR, 32'd0, 32'(k), 5'd6, ZERO_ROB, 5'(k));
            tick();
            checks++; if (bus.full_to_if !== (k >= 15)) begin
                failures++; $display("FAIL fill_full k=%0d got=%b exp=%b", k, bus.full_to_if, (k >= 15)); end
        end
        clear_inputs();
        checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL fill_no_issue got=%b exp=0", bus.ena_to_alu); end
        bus.valid_from_rs_cdb  = 1'b1;
        bus.rob_id_from_rs_cdb = 5'd6;
        bus.result_from_rs_cdb = 32'h60;
        tick();
        clear_inputs();
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++; if (bus.ena_to_alu !== 1'b1 || bus.rob_id_to_alu !== 5'(k) || bus.V1_to_alu !== 32'h60) begin
                failures++; $display("FAIL fill_issue k=%0d got ena=%b rob=%0d V1=%h exp 1/%0d/60", k, bus.ena_to_alu, bus.rob_id_to_alu, bus.V1_to_alu, k); end
            checks++; if (bus.full_to_if !== (k < 2)) begin
                failures++; $display("FAIL fill_drain_full k=%0d got=%b exp=%b", k, bus.full_to_if, (k < 2)); end
        end
        tick();
        checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL fill_drained got=%b exp=0", bus.ena_to_alu); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) begin
            dispatch(OPENUM_ADD, 32'd0, 32'd0, 5'd7, ZERO_ROB, 5'(20 + k));
            tick();
        end
        dispatch(OPENUM_ADD, 32'd1, 32'd1, ZERO_ROB, ZERO_ROB, 5'd30);
        bus.commit_jump_flag_from_rob = 1'b1;
        tick();
        clear_inputs();
        checks++; if (bus.ena_to_alu !== 1'b0 || bus.full_to_if !== 1'b0) begin
            failures++; $display("FAIL flush_edge got ena=%b full=%b exp 0/0", bus.ena_to_alu, bus.full_to_if); end
        tick();
        checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL flush_alloc_dropped got=%b exp=0", bus.ena_to_alu); end
        bus.valid_from_rs_cdb  = 1'b1;
        bus.rob_id_from_rs_cdb = 5'd7;
        bus.result_from_rs_cdb = 32'h77;
        tick();
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL flush_no_issue k=%0d got=%b exp=0", k, bus.ena_to_alu); end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            dispatch(OPENUM_SUB, 32'd3, 32'd4, 5'd8, ZERO_ROB, 5'(24 + k));
            tick();
        end
        clear_inputs();
        bus.valid_from_ls_cdb  = 1'b1;
        bus.rob_id_from_ls_cdb = 5'd8;
        bus.result_from_ls_cdb = 32'h88;
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        checks++; if (bus.ena_to_alu !== 1'b0 || bus.full_to_if !== 1'b0) begin
            failures++; $display("FAIL rstmid_ctrl got ena=%b full=%b exp 0/0", bus.ena_to_alu, bus.full_to_if); end
        checks++; if (bus.V1_to_alu !== 32'd0 || bus.V2_to_alu !== 32'd0 || bus.pc_to_alu !== 32'd0
                      || bus.imm_to_alu !== 32'd0 || bus.rob_id_to_alu !== ZERO_ROB || bus.openum_to_alu !== OPENUM_NOP) begin
            failures++; $display("FAIL rstmid_data got V1=%h V2=%h pc=%h imm=%h rob=%0d op=%0d exp all 0",
                                 bus.V1_to_alu, bus.V2_to_alu, bus.pc_to_alu, bus.imm_to_alu, bus.rob_id_to_alu, bus.openum_to_alu); end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.ena_to_alu !== 1'b0) begin failures++; $display("FAIL rstmid_no_issue k=%0d got=%b exp=0", k, bus.ena_to_alu); end
        end
    endtask

    initial begin
        bus.rdy = 1'b1;
        clear_inputs();
        test_reset();
        test_ready_dispatch();
        test_rdy_freeze();
        test_wakeup();
        test_simul_snoop();
        test_fill();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reservation_station.md
# reservation_station

Holds ALU-class instructions (everything except loads/stores) that the dispatcher has decoded and renamed, until both source operands are available. Snoops both CDBs (ALU and load/store) to wake waiting operands. Issues one ready instruction per cycle to the ALU. Sits between the dispatcher and the ALU/rs-CDB producer, and is flushed by a committed mispredicted jump.

## Interface
Parameters:
- RS_SIZE, 16, number of entries (power of two, ≥ 4)
- RS_ID_W, 4, log2(RS_SIZE)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low = freeze all state, no issue
- ena_from_dsp  in  1  allocate one entry this cycle
- openum_from_dsp  in  OPENUM_TYPE  operation enum
- V1_from_dsp / V2_from_dsp  in  32 each  operand values (valid when matching Q = ZERO_ROB)
- Q1_from_dsp / Q2_from_dsp  in  ROB_ID_TYPE each  producer tags, ZERO_ROB = ready
- pc_from_dsp  in  32  instruction pc
- imm_from_dsp  in  32  immediate
- rob_id_from_dsp  in  ROB_ID_TYPE  destination ROB tag
- valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb  in  1 / ROB_ID_TYPE / 32  ALU broadcast
- valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb  in  1 / ROB_ID_TYPE / 32  LSB broadcast
- commit_jump_flag_from_rob  in  1  flush request
- full_to_if  out  1  fetch stall request
- ena_to_alu  out  1  issue valid (one cycle pulse per instruction)
- openum_to_alu, V1_to_alu, V2_to_alu, pc_to_alu, imm_to_alu, rob_id_to_alu  out  matching widths  issued instruction fields

## Operation
- Entry state: busy, openum, V1, V2, Q1, Q2, pc, imm, rob_id.
- Allocation: when ena_from_dsp is high, write to the lowest-index entry that is free at the start of the cycle.
- Incoming operand snoop: if Qx_from_dsp ≠ ZERO_ROB and it matches a valid CDB tag this cycle, store the CDB result as Vx and set Qx to ZERO_ROB.
  - The rs CDB has priority if both CDBs match; by the ROB contract they never carry the same tag.
- Wakeup: every busy entry whose Q1 or Q2 matches a valid CDB tag captures the result and clears that Q to ZERO_ROB.
  - Both CDBs can update different operands, or different entries, in the same cycle.
- Issue readiness: an entry is ready when busy, Q1 = ZERO_ROB and Q2 = ZERO_ROB, using registered state only.
  - An entry woken in cycle t issues at t+1 at the earliest.
  - An entry allocated in cycle t issues at t+1 at the earliest.
- Issue: the lowest-index ready entry drives the registered ALU outputs, ena_to_alu is 1, and busy is cleared. No ready entry → ena_to_alu is 0; the data outputs hold their previous values.
- The slot freed by an issue is not reused for an allocation in the same cycle.
- full_to_if = 1 when busy count ≥ RS_SIZE − 1. This reserves one slot for the dispatch already in flight. It is combinational from registered state.
- Allocation while all entries are busy is a protocol violation: the instruction is dropped and the bench flags it.
- Flush: commit_jump_flag_from_rob = 1 clears every busy bit and drives ena_to_alu to 0 at the next edge. An allocation in the same cycle is discarded. Flush has priority over everything except rst.
- rdy = 0: no state changes, ena_to_alu is 0 at the next edge, and CDB/dispatch inputs are ignored.
- Reset: all busy bits = 0; ena_to_alu, openum_to_alu, V1/V2/pc/imm_to_alu and rob_id_to_alu = 0; full_to_if = 0.

## Timing
- Dispatch at edge t → entry valid after t → earliest ena_to_alu high after edge t+1.
- CDB broadcast in cycle t → wakeup visible after edge t → issue after edge t+1.
- Throughput: one issue and one allocation per cycle.
- Issue latency from ready: one edge.
- full_to_if changes in the same cycle as the busy count.

## Structure
- defines.v holds OPENUM_TYPE, ROB_ID_TYPE, ZERO_ROB, the OPENUM_* codes, RS_SIZE, and RS_ID_TYPE.
- Sub-module rs_find_first: a parameterised lowest-set-bit finder over a RS_SIZE-bit vector, with outputs found and index. It is instantiated twice, for the free vector and the ready vector.
- Per-entry wakeup compare logic is a generate loop inside reservation_station.

## Test plan
- Ready dispatch: ADD, Q1 = Q2 = 0, V1 = 5, V2 = 7, rob_id = 3 at edge 0 → ena_to_alu = 1 after edge 1 with V1 = 5, V2 = 7, rob_id_to_alu = 3.
- Dependency wakeup: dispatch Q1 = 2; two cycles later valid_from_ls_cdb = 1, tag 2, data 0xDEAD → issue on the following cycle with V1_to_alu = 0xDEAD.
- Simultaneous snoop: dispatch Q1 = 4, Q2 = 5 in the same cycle that the rs CDB broadcasts tag 4 (data 9) and the ls CDB broadcasts tag 5 (data 11) → issue next cycle with V1 = 9, V2 = 11.
- Fill: 15 stalled entries (all Q1 = 6) → full_to_if = 1; 16th dispatch accepted. Then broadcast tag 6 → 16 consecutive issues in index order, and full_to_if drops after the 2nd issue.
- Flush: 4 waiting entries plus a concurrent dispatch while commit_jump_flag_from_rob = 1 → busy count 0 and no ena_to_alu afterward, even when tags are later broadcast.
- Reset mid-operation: assert rst with 3 ready entries → all outputs 0 next cycle and no issues after release.
